// File: rtl/register_file_sb.sv
// Register file with r0 hardwired to zero, same-cycle write-through bypass,
// and a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module register_file_sb #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      WrEn,
  input  logic [ADDR_BITS-1:0]      Aw,
  input  logic [WIDTH-1:0]          Dw,
  input  logic [ADDR_BITS-1:0]      Aa,
  input  logic [ADDR_BITS-1:0]      Ab,
  output logic [WIDTH-1:0]          Da,
  output logic [WIDTH-1:0]          Db,
  input  logic                      IssEn,
  input  logic [ADDR_BITS-1:0]      Ai,
  output logic                      stall,
  output logic [(2**ADDR_BITS)-1:0] busy_vec
);

  localparam int DEPTH = 2**ADDR_BITS;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr_any;
  logic hz_a;
  logic hz_b;
  logic hz_w;
  logic iss_ok;

  always_comb begin
    wr_any = WrEn && (Aw != '0);
  end

  // Read ports: r0 is always zero, and a landing write-back forwards its data.
  always_comb begin
    if (Aa == '0) begin
      Da = '0;
    end else if (WrEn && (Aw == Aa)) begin
      Da = Dw;
    end else begin
      Da = mem_q[Aa];
    end
    if (Ab == '0) begin
      Db = '0;
    end else if (WrEn && (Aw == Ab)) begin
      Db = Dw;
    end else begin
      Db = mem_q[Ab];
    end
  end

  // A write-back landing this cycle resolves the hazard on its register.
  always_comb begin
    hz_a   = busy_q[Aa] && !(WrEn && (Aw == Aa));
    hz_b   = busy_q[Ab] && !(WrEn && (Aw == Ab));
    hz_w   = busy_q[Ai] && (Ai != '0) && !(WrEn && (Aw == Ai));
    stall  = IssEn && (hz_a || hz_b || hz_w);
    iss_ok = IssEn && !stall && (Ai != '0);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_any) begin
      mem_d[Aw] = Dw;
    end
    mem_d[0] = '0;
  end

  // Set is applied after clear so a new producer on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_any) begin
      busy_d[Aw] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[Ai] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: stimulus queues expected values,
// a monitor process pops and compares them when a sample is requested.
module tb_register_file_sb;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 5;
  localparam int K_DA = 0, K_DB = 1, K_STALL = 2, K_BUSY = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              WrEn;
  logic [4:0]        Aw;
  logic [WIDTH-1:0]  Dw;
  logic [4:0]        Aa;
  logic [4:0]        Ab;
  logic [WIDTH-1:0]  Da;
  logic [WIDTH-1:0]  Db;
  logic              IssEn;
  logic [4:0]        Ai;
  logic              stall;
  logic [31:0]       busy_vec;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  bit   sample_req = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  register_file_sb #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .Aw(Aw), .Dw(Dw),
    .Aa(Aa), .Ab(Ab), .Da(Da), .Db(Db), .IssEn(IssEn), .Ai(Ai),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Monitor: drains the expectation queue against the live outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      wait (sample_req);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_DA:    act = Da;
          K_DB:    act = Db;
          K_STALL: act = {31'd0, stall};
          default: act = busy_vec;
        endcase
        n_vec++;
        if (act !== e.val) begin
          n_err++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
        end else begin
          $display("ok   %s: 0x%08h", e.name, act);
        end
      end
      sample_req = 1'b0;
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    sample_req = 1'b1;
    for (int i = 0; i < 50 && sample_req; i++) #1;
    if (sample_req) begin
      n_vec++;
      n_err++;
      $display("FAIL monitor_timeout: got no response, expected queue drained");
      sample_req = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] aw, input logic [31:0] dw,
                       input logic [4:0] aa, input logic [4:0] ab,
                       input logic ie, input logic [4:0] ai);
    WrEn = we; Aw = aw; Dw = dw; Aa = aa; Ab = ab; IssEn = ie; Ai = ai;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    expect_val("reset_da", K_DA, 0);
    expect_val("reset_db", K_DB, 0);
    expect_val("reset_stall", K_STALL, 0);
    expect_val("reset_busy", K_BUSY, 0);
    check_now();
    rst_n = 1'b1;
    tick();

    // Write 69 to r4 with bypass, then read back from the array.
    drive(1, 4, 69, 4, 4, 0, 0);
    expect_val("bypass_da_r4", K_DA, 69);
    expect_val("bypass_db_r4", K_DB, 69);
    check_now();
    tick();
    drive(0, 4, 69, 4, 4, 0, 0);
    expect_val("stored_da_r4", K_DA, 69);
    expect_val("stored_db_r4", K_DB, 69);
    check_now();

    // Writes to r0 are discarded.
    drive(1, 0, 69, 0, 0, 0, 0);
    expect_val("r0_bypass_da", K_DA, 0);
    check_now();
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_val("r0_da", K_DA, 0);
    expect_val("r0_db", K_DB, 0);
    expect_val("r0_busy", K_BUSY, 0);
    check_now();

    // Write enable respected.
    drive(1, 25, 420, 0, 0, 0, 0);
    tick();
    drive(0, 25, 42, 4, 25, 0, 0);
    tick();
    tick();
    expect_val("wren_da_r4", K_DA, 69);
    expect_val("wren_db_r25", K_DB, 420);
    check_now();

    // Issue to r7, then RAW stall on r7, resolved by a landing write-back.
    drive(0, 0, 0, 0, 0, 1, 7);
    expect_val("issue7_stall", K_STALL, 0);
    check_now();
    tick();
    drive(0, 0, 0, 7, 0, 1, 8);
    expect_val("issue7_busy", K_BUSY, 32'h0000_0080);
    expect_val("raw_a_stall", K_STALL, 1);
    check_now();
    tick();
    expect_val("raw_hold_busy", K_BUSY, 32'h0000_0080);
    check_now();
    drive(1, 7, 5, 7, 0, 1, 8);
    expect_val("raw_resolved_stall", K_STALL, 0);
    expect_val("raw_resolved_da", K_DA, 5);
    check_now();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_val("after_wb7_busy", K_BUSY, 32'h0000_0100);
    check_now();

    // WAW stall on r8, and busy ignored without IssEn.
    drive(0, 0, 0, 0, 0, 1, 8);
    expect_val("waw_stall", K_STALL, 1);
    check_now();
    drive(0, 0, 0, 0, 8, 0, 0);
    expect_val("no_issue_stall", K_STALL, 0);
    check_now();

    // Same-edge clear and set on r9: set wins.
    drive(0, 0, 0, 0, 0, 1, 9);
    tick();
    drive(0, 0, 0, 0, 9, 1, 0);
    expect_val("raw_b_stall", K_STALL, 1);
    check_now();
    drive(1, 9, 77, 0, 0, 1, 9);
    expect_val("clrset_stall", K_STALL, 0);
    check_now();
    tick();
    drive(0, 0, 0, 9, 0, 0, 0);
    expect_val("clrset_busy", K_BUSY, 32'h0000_0300);
    expect_val("clrset_da_r9", K_DA, 77);
    check_now();

    // Asynchronous reset between edges.
    drive(0, 0, 0, 0, 0, 1, 7);
    tick();
    drive(0, 0, 0, 4, 25, 0, 0);
    expect_val("pre_rst_busy", K_BUSY, 32'h0000_0380);
    expect_val("pre_rst_da_r4", K_DA, 69);
    check_now();
    rst_n = 1'b0;
    #1;
    expect_val("async_rst_da", K_DA, 0);
    expect_val("async_rst_db", K_DB, 0);
    expect_val("async_rst_busy", K_BUSY, 0);
    check_now();
    rst_n = 1'b1;
    drive(1, 3, 11, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 3, 4, 0, 0);
    expect_val("post_rst_da_r3", K_DA, 11);
    expect_val("post_rst_db_r4", K_DB, 0);
    check_now();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Register file with a write-back scoreboard, for the single-issue CPU datapath.
- Provides 2 read ports and 1 write port, with `r0` hardwired to zero and same-cycle write-through bypass.
- Tracks one busy bit per register. A register is marked busy when an instruction that will write it issues, and cleared when its write-back lands.
- Raises `stall` on RAW or WAW hazards so the issue stage holds its instruction.

Parameters:
- `WIDTH`, 32, data width of each register.
- `ADDR_BITS`, 5, address width. Depth is `2**ADDR_BITS`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous reset, active-low.
- `WrEn`  in  1  write-back enable.
- `Aw`  in  `ADDR_BITS`  write-back address.
- `Dw`  in  `WIDTH`  write-back data.
- `Aa`  in  `ADDR_BITS`  read port A address.
- `Ab`  in  `ADDR_BITS`  read port B address.
- `Da`  out  `WIDTH`  read port A data.
- `Db`  out  `WIDTH`  read port B data.
- `IssEn`  in  1  issue stage requests to issue an instruction that reads `Aa`/`Ab` and writes `Ai`.
- `Ai`  in  `ADDR_BITS`  destination register of the issuing instruction (0 = no destination).
- `stall`  out  1  issue blocked this cycle.
- `busy_vec`  out  `2**ADDR_BITS`  current scoreboard bits, bit n = register n pending.

Behaviour:
- Reset (`rst_n` low, asynchronous, takes effect without a clock edge):
  - all registers clear to 0;
  - `busy_vec` clears to 0;
  - hence `Da` = `Db` = 0 and `stall` = 0 while `IssEn` = 0.
- Reset deasserted mid-operation: state stays cleared; the next rising edge behaves normally.
- Write: on a rising edge with `WrEn` = 1 and `Aw` != 0, `reg[Aw]` <= `Dw`. A write to `Aw` = 0 is discarded.
- Write to a register whose busy bit is clear: the data is still written and no error is flagged. This lets bench-driven writes work without an issue step.
- Read: `Da`/`Db` are combinational, with zero-cycle latency from `Aa`/`Ab`.
  - Address 0 always reads 0.
  - Bypass: if `WrEn` = 1 and `Aw` == `Aa` and `Aa` != 0, then `Da` = `Dw` in the same cycle. `Db` follows the same rule with `Ab`.
  - Otherwise `Da` = `reg[Aa]` and `Db` = `reg[Ab]`.
- Hazard detect (combinational):
  - `hzA` = `busy[Aa]` & !(`WrEn` & `Aw` == `Aa`).
  - `hzB` = `busy[Ab]` & !(`WrEn` & `Aw` == `Ab`).
  - `hzW` = `busy[Ai]` & (`Ai` != 0) & !(`WrEn` & `Aw` == `Ai`).
  - `stall` = `IssEn` & (`hzA` | `hzB` | `hzW`).
  - A write-back landing in the same cycle resolves its hazard, since the bypass supplies the value.
- Scoreboard update on the rising edge:
  - Clear: if `WrEn` and `Aw` != 0, `busy[Aw]` <= 0.
  - Set: if `IssEn` and !`stall` and `Ai` != 0, `busy[Ai]` <= 1.
  - Clear and set on the same register in the same edge: set wins, because the new producer is outstanding.
  - `busy[0]` is constant 0.
- Stalled issue: no scoreboard change. The issue stage holds `IssEn`/`Ai`/`Aa`/`Ab` until `stall` drops.
- Multiple writes to one register: each write-back clears busy. The scoreboard tracks at most one outstanding producer per register, which `hzW` guarantees.
- All arithmetic is unsigned address compare. There is no wrap-around; addresses beyond the depth are impossible by width.

Test Plan:
- Reset, then `WrEn`=1, `Aw`=4, `Dw`=69, `Aa`=`Ab`=4, one clock -> during the cycle `Da`=`Db`=69 (bypass); after the edge `WrEn`=0 and `Da`=`Db`=69.
- `WrEn`=1, `Aw`=0, `Dw`=69, `Aa`=`Ab`=0, two clocks -> `Da`=`Db`=0 and `busy_vec`=0.
- Write 420 to reg 25 with `WrEn`=1, then `WrEn`=0, `Aw`=25, `Dw`=42, two clocks, `Aa`=4, `Ab`=25 -> `Da`=69, `Db`=420 (write enable respected).
- `IssEn`=1, `Ai`=7, `Aa`=`Ab`=0, one clock -> `busy_vec[7]`=1. Next cycle `IssEn`=1, `Aa`=7, `Ai`=8 -> `stall`=1 and `busy_vec[8]` stays 0. Then `WrEn`=1, `Aw`=7, `Dw`=5 in the same cycle -> `stall`=0, `Da`=5; after the edge `busy_vec[7]`=0 and `busy_vec[8]`=1.
- `busy[9]`=1; in the same cycle `WrEn`=1, `Aw`=9, `IssEn`=1, `Ai`=9, `Aa`=`Ab`=0 -> `stall`=0; after the edge `busy_vec[9]`=1 (set wins) and `reg[9]`=`Dw`.
- With `reg[4]`=69 and `busy_vec[7]`=1, pulse `rst_n` low between clock edges -> `Da` at `Aa`=4 reads 0 and `busy_vec`=0 immediately, with no clock edge.
